// File: rtl/switch_bounce_gen.sv
// Mechanical switch emulator: follows a clean requested level btn_i, but drives
// sw_o through a deterministic burst of bounce toggles shaped by an 8-bit LFSR.
// The output then holds the new level for STABLE_CYC cycles, and settled_o pulses.
// The LFSR steps only when a hold interval is loaded. The bounce pattern therefore
// depends only on SEED and on how many intervals have been drawn since reset.
module switch_bounce_gen #(
    parameter int unsigned N_BOUNCE    = 4,      // bounce pairs per transition, 0..15
    parameter int unsigned MIN_W       = 3,      // minimum hold per bounce level, 1..239
    parameter logic [3:0]  JITTER_MASK = 4'hF,   // mask on lfsr[3:0] added to MIN_W
    parameter int unsigned STABLE_CYC  = 5,      // final-level hold before settled, 1..255
    parameter logic [7:0]  SEED        = 8'h01   // LFSR reset value, zero maps to 8'h01
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic sw_o,
    output logic busy_o,
    output logic settled_o
);

    // An all-zero Fibonacci LFSR would lock up, so zero is replaced by one.
    localparam logic [7:0] SeedEff   = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [7:0] MinW      = MIN_W[7:0];
    localparam logic [7:0] StableCyc = STABLE_CYC[7:0];
    localparam logic [4:0] Toggles   = 5'(2 * N_BOUNCE);
    localparam bit         NoBounce  = (N_BOUNCE == 0);

    typedef enum logic [1:0] {
        StIdle,
        StBounce,
        StSettle
    } state_e;

    state_e      state_q;
    logic [7:0]  lfsr_q;
    logic [7:0]  timer_q;
    logic [4:0]  remaining_q;
    logic [7:0]  stable_q;
    logic        sw_q;
    logic        busy_q;
    logic        settled_q;

    logic [7:0]  lfsr_next;
    logic [7:0]  interval;

    // Next LFSR value (taps 8,6,5,4) and the hold interval drawn from the current value.
    always_comb begin
        lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        interval  = MinW + {4'b0000, lfsr_q[3:0] & JITTER_MASK};
    end

    // Sequence FSM: the state register, the counters, and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            lfsr_q      <= SeedEff;
            timer_q     <= 8'd0;
            remaining_q <= 5'd0;
            stable_q    <= 8'd0;
            sw_q        <= 1'b0;
            busy_q      <= 1'b0;
            settled_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    busy_q    <= 1'b0;
                    settled_q <= 1'b0;
                    if (btn_i != sw_q) begin
                        // The first edge always moves to the requested level.
                        sw_q        <= btn_i;
                        busy_q      <= 1'b1;
                        timer_q     <= interval;
                        remaining_q <= Toggles;
                        lfsr_q      <= lfsr_next;
                        if (NoBounce) begin
                            stable_q <= StableCyc;
                            state_q  <= StSettle;
                        end else begin
                            state_q  <= StBounce;
                        end
                    end
                end

                StBounce: begin
                    if (timer_q == 8'd1) begin
                        // Each toggle draws a fresh interval, including the final toggle.
                        sw_q        <= ~sw_q;
                        timer_q     <= interval;
                        lfsr_q      <= lfsr_next;
                        remaining_q <= remaining_q - 5'd1;
                        if (remaining_q == 5'd1) begin
                            stable_q <= StableCyc;
                            state_q  <= StSettle;
                        end
                    end else begin
                        timer_q <= timer_q - 8'd1;
                    end
                end

                StSettle: begin
                    if (settled_q) begin
                        settled_q <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= StIdle;
                    end else if (stable_q == 8'd1) begin
                        settled_q <= 1'b1;
                        stable_q  <= 8'd0;
                    end else begin
                        stable_q <= stable_q - 8'd1;
                    end
                end

                default: begin
                    state_q   <= StIdle;
                    busy_q    <= 1'b0;
                    settled_q <= 1'b0;
                end
            endcase
        end
    end

    assign sw_o      = sw_q;
    assign busy_o    = busy_q;
    assign settled_o = settled_q;

    // settled must only be seen while busy and in the settle phase; idle means not busy.
    a_settled_in_settle: assert property (@(posedge clk_i) disable iff (rst_i)
        settled_q |-> (busy_q && state_q == StSettle));
    a_idle_not_busy: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == StIdle) |-> !busy_q);

endmodule

// File: tb/tb_switch_bounce_gen.sv
// Bench for switch_bounce_gen. Four configurations are instantiated and driven
// by the same btn/rst:
//   0: two bounce pairs with fixed widths
//   1: no bounce
//   2: full jitter from SEED 1
//   3: full jitter from SEED 0, which must behave exactly like SEED 1
// Each transition is modelled as a schedule of absolute toggle times. Literal
// timelines pin the model in the directed scenarios.
module tb_switch_bounce_gen;

    localparam int NI = 4;
    localparam int CN[NI]    = '{2, 0, 4, 4};
    localparam int CMIN[NI]  = '{3, 3, 3, 3};
    localparam int CMASK[NI] = '{0, 0, 15, 15};
    localparam int CST[NI]   = '{5, 5, 5, 5};
    localparam int CSEED[NI] = '{1, 1, 1, 0};

    // Hand-derived toggle timelines (cycle offsets from the btn change), padded with 100000.
    localparam int LA0[10] = '{1, 4, 7, 10, 13, 20, 23, 26, 29, 32};
    localparam int LB0[10] = '{1, 4, 7, 100000, 100000, 100000, 100000, 100000, 100000, 100000};
    localparam int LB1[10] = '{10, 13, 16, 19, 22, 100000, 100000, 100000, 100000, 100000};
    localparam int LBJ[10] = '{10, 14, 19, 26, 37, 41, 47, 57, 74, 100000};

    logic clk;
    logic rst;
    logic btn;
    logic sw[NI];
    logic busy[NI];
    logic settled[NI];

    int total;
    int bad;
    bit chk_en;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        switch_bounce_gen #(
            .N_BOUNCE   (CN[g]),
            .MIN_W      (CMIN[g]),
            .JITTER_MASK(4'(CMASK[g])),
            .STABLE_CYC (CST[g]),
            .SEED       (8'(CSEED[g]))
        ) u_dut (
            .clk_i    (clk),
            .rst_i    (rst),
            .btn_i    (btn),
            .sw_o     (sw[g]),
            .busy_o   (busy[g]),
            .settled_o(settled[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic bit par_list(input int lst[10], input int j);
        bit p = 1'b0;
        for (int k = 0; k < 10; k++) if (lst[k] <= j) p = ~p;
        return p;
    endfunction

    // Behavioural model: on launch, build the complete schedule for the transition.
    // Every later output value is read from that schedule.
    int         cyc;
    bit         m_act[NI];
    bit         target[NI];
    logic [7:0] m_lfsr[NI];
    int         tog[NI][32];
    int         ntog[NI];
    int         settle_t[NI];
    bit         m_sw[NI];
    bit         m_busy[NI];
    bit         m_settled[NI];

    always @(posedge clk) begin
        int oc;
        int t;
        int w;
        bit p;
        oc  = cyc;
        cyc = cyc + 1;
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                m_act[i]     = 1'b0;
                m_sw[i]      = 1'b0;
                m_busy[i]    = 1'b0;
                m_settled[i] = 1'b0;
                m_lfsr[i]    = (CSEED[i] == 0) ? 8'h01 : 8'(CSEED[i]);
            end else begin
                if ((!m_act[i] || oc > settle_t[i]) && (btn != m_sw[i])) begin
                    m_act[i]  = 1'b1;
                    target[i] = btn;
                    t         = cyc;
                    w         = CMIN[i] + int'(m_lfsr[i][3:0] & 4'(CMASK[i]));
                    m_lfsr[i] = lfsr_step(m_lfsr[i]);
                    ntog[i]   = 2 * CN[i];
                    for (int k = 0; k < ntog[i]; k++) begin
                        t          = t + w;
                        tog[i][k]  = t;
                        w          = CMIN[i] + int'(m_lfsr[i][3:0] & 4'(CMASK[i]));
                        m_lfsr[i]  = lfsr_step(m_lfsr[i]);
                    end
                    settle_t[i] = t + CST[i];
                end
                if (m_act[i] && cyc <= settle_t[i]) begin
                    p = 1'b0;
                    for (int k = 0; k < ntog[i]; k++) if (tog[i][k] <= cyc) p = ~p;
                    m_sw[i]      = target[i] ^ p;
                    m_busy[i]    = 1'b1;
                    m_settled[i] = (cyc == settle_t[i]);
                end else begin
                    m_busy[i]    = 1'b0;
                    m_settled[i] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input int inst, input int j, input logic act,
                       input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d t=%0d got=%b want=%b", name, inst, j, act, exp);
        end
    endtask

    task automatic new_cycle();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle comparison of every instance against the model, sampled mid-cycle.
    task automatic cmp_model();
        @(negedge clk);
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                chk("sw", i, cyc, sw[i], m_sw[i]);
                chk("busy", i, cyc, busy[i], m_busy[i]);
                chk("settled", i, cyc, settled[i], m_settled[i]);
            end
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        chk_en = 1'b0;
        cyc    = 0;
        rst    = 1'b1;
        btn    = 1'b0;
        repeat (3) new_cycle();
        chk_en = 1'b1;
        cmp_model();
        chk("rst_sw", 0, cyc, sw[0], 1'b0);
        chk("rst_busy", 0, cyc, busy[0], 1'b0);
        chk("rst_settled", 2, cyc, settled[2], 1'b0);
        rst = 1'b0;
        repeat (3) begin new_cycle(); cmp_model(); end

        // Rise at j=0, then fall at j=5 while the first sequence is still bouncing.
        for (int j = 0; j <= 40; j++) begin
            new_cycle();
            if (j == 0) btn = 1'b1;
            if (j == 5) btn = 1'b0;
            cmp_model();
            chk("a0_sw", 0, j, sw[0], par_list(LA0, j));
            chk("a0_busy", 0, j, busy[0], (j >= 1 && j <= 18) || (j >= 20 && j <= 37));
            chk("a0_settled", 0, j, settled[0], (j == 18) || (j == 37));
            chk("a1_sw", 1, j, sw[1], (j >= 1 && j <= 7));
            chk("a1_busy", 1, j, busy[1], (j >= 1 && j <= 6) || (j >= 8 && j <= 13));
            chk("a1_settled", 1, j, settled[1], (j == 6) || (j == 13));
        end

        // Reset lands mid-bounce with btn held high; every instance restarts from the seed.
        for (int j = 0; j <= 85; j++) begin
            new_cycle();
            if (j == 0) btn = 1'b1;
            if (j == 8) rst = 1'b1;
            if (j == 9) rst = 1'b0;
            cmp_model();
            chk("b0_sw", 0, j, sw[0], (j < 9) ? par_list(LB0, j) : par_list(LB1, j));
            chk("b0_busy", 0, j, busy[0], (j >= 1 && j <= 8) || (j >= 10 && j <= 27));
            chk("b0_settled", 0, j, settled[0], j == 27);
            chk("b1_sw", 1, j, sw[1], (j < 9) ? (j >= 1) : (j >= 10));
            chk("b1_settled", 1, j, settled[1], (j == 6) || (j == 15));
            if (j >= 9) begin
                for (int i = 2; i < NI; i++) begin
                    chk("bj_sw", i, j, sw[i], par_list(LBJ, j));
                    chk("bj_busy", i, j, busy[i], (j >= 10 && j <= 79));
                    chk("bj_settled", i, j, settled[i], j == 79);
                end
            end
        end

        btn = 1'b0;
        repeat (120) begin new_cycle(); cmp_model(); end

        // Random traffic: a phase of fast glitchy toggling, then a phase of slow toggling.
        // Both phases include occasional resets.
        for (int n = 0; n < 4000; n++) begin
            new_cycle();
            if (n < 2000) begin
                if ($urandom_range(0, 15) == 0) btn = ~btn;
            end else begin
                if ($urandom_range(0, 149) == 0) btn = ~btn;
            end
            rst = ($urandom_range(0, 499) == 0);
            cmp_model();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/switch_bounce_gen.md
Name: switch_bounce_gen

Overview:
- Synthesizable mechanical-switch emulator: the transmitting end of the debounce path.
- Takes a clean target level `btn` and drives `sw` with a deterministic, LFSR-shaped burst of bounce toggles, then settles to the new level.
- Used as the stimulus source for debouncer benches and on-board self-test, where it feeds the debouncer's `sw` input directly.

Parameters:
- N_BOUNCE, 4: bounce pairs per transition; `sw` makes 2*N_BOUNCE extra toggles; range 0..15.
- MIN_W, 3: minimum hold time of each bounce level, in clk cycles; range 1..239.
- JITTER_MASK, 4'hF: mask on lfsr[3:0] added to MIN_W; 0 gives fixed widths.
- STABLE_CYC, 5: cycles `sw` holds the final level before `settled` pulses; range 1..255.
- SEED, 8'h01: LFSR reset value; 8'h00 is substituted with 8'h01.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- btn  input  1  clean requested switch level
- sw  output  1  emulated noisy switch output, registered
- busy  output  1  high while a transition sequence is in progress, registered
- settled  output  1  one-cycle pulse when the final level has been held STABLE_CYC cycles

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high. All state changes on the rising clk edge.
- Reset values:
  - sw=0, busy=0, settled=0
  - state=IDLE, lfsr=SEED (or 8'h01 if SEED=0)
  - timer=0, remaining=0, stable counter=0
- States: IDLE, BOUNCE, SETTLE.
- IDLE:
  - Each cycle, compare btn with sw.
  - If they differ at cycle k: at edge k+1, sw<=btn, busy<=1, timer<=interval, remaining<=2*N_BOUNCE, lfsr advances one step.
  - Next state is BOUNCE, or SETTLE if N_BOUNCE=0.
- interval = MIN_W + (lfsr[3:0] & JITTER_MASK), computed on 8 bits, using the lfsr value before the advance. Never overflows within the legal ranges.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. It advances only when a new interval is loaded, never per cycle, so the bounce pattern is a pure function of SEED and transition count.
- BOUNCE:
  - timer decrements each cycle; each sw level is held exactly interval cycles.
  - On the cycle timer would expire: sw<=~sw, remaining decrements, new interval loaded, lfsr advances.
  - When the toggle taking remaining to 0 occurs (cycle T), go to SETTLE. sw equals the target level, since the number of toggles is even.
- SETTLE:
  - The counter is loaded with STABLE_CYC at entry; sw is held.
  - settled=1 for exactly one cycle at T+STABLE_CYC (or k+1+STABLE_CYC when N_BOUNCE=0). busy stays 1 in that cycle.
  - Next edge: busy<=0, state IDLE.
- btn changes during BOUNCE or SETTLE are ignored; there is no queuing. On return to IDLE, btn is re-compared with sw, and a mismatch starts a fresh sequence. The first new sw change is therefore no earlier than the cycle after busy falls, +1.
- btn glitch in IDLE lasting one cycle still launches a full sequence to that level, followed by a sequence back.
- Reset mid-sequence takes effect at the next edge: sw=0, lfsr reloads SEED. If btn=1 after reset, a new sequence starts from IDLE.
- settled and busy are never asserted in IDLE. settled is never asserted while sw is mid-bounce.

Test Plan:
1. Fixed widths. Config: N_BOUNCE=2, MIN_W=3, JITTER_MASK=0, STABLE_CYC=5; btn 0->1 sampled at cycle k. Required response:
   - sw=1 at k+1; toggles at k+4, k+7, k+10, k+13; final sw=1.
   - settled high only at k+18.
   - busy high k+1..k+18, low at k+19.
2. No bounce. N_BOUNCE=0, STABLE_CYC=5; btn 1->0 at k -> sw=0 at k+1 with no toggles; settled at k+6; busy low at k+7.
3. btn change during BOUNCE. btn 0->1 at k, back to 0 at k+5 (scenario 1 config) -> the first sequence completes unchanged with settled at k+18. Then, from IDLE, a 1->0 sequence starts: sw=0 at k+20, settled at k+37.
4. Reset mid-operation. rst=1 at k+8 during BOUNCE, btn=1 -> sw=0, busy=0, settled=0 at k+9. After rst drops, a full sequence restarts and matches scenario 1 timing relative to release.
5. Jitter determinism. JITTER_MASK=4'hF, SEED=8'h01, N_BOUNCE=4, MIN_W=3 -> every hold width lies in 3..18. Two runs separated by reset produce bit-identical sw waveforms. SEED=0 produces the same waveform as SEED=8'h01.
6. Loopback. sw drives the team debouncer; btn toggles every 2000 cycles -> the debounced output changes exactly once per btn edge, and no glitch reaches it.
